// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues PCs to a synchronous imem and queues tagged responses for decode.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to the head when the queue is empty.
module fetch_queue #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   pc_override,
  output logic [PC_WIDTH-1:0]    pc_in,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_e;

  logic [INSTR_WIDTH-1:0] data_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem   [DEPTH];

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                infl_q, infl_d;
  logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;
  state_e              state_q, state_d;

  logic [CNT_W-1:0] occupancy;
  logic             credit_ok, issue, queue_empty, bypass_hit;
  logic             pop, q_pop, push;

  // Credit counts the in-flight word; a same-cycle pop is deliberately ignored
  // so instr_ready never reaches imem_req combinationally.
  assign occupancy   = count_q + CNT_W'(infl_q);
  assign credit_ok   = occupancy < CNT_W'(DEPTH);
  assign issue       = !rst && !redirect_valid && credit_ok;
  assign queue_empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = queue_empty && infl_q && !redirect_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    instr_valid = !queue_empty || bypass_hit;
    instr_out   = '0;
    instr_pc    = '0;
    if (!queue_empty) begin
      instr_out = data_mem[rd_ptr_q];
      instr_pc  = pc_mem[rd_ptr_q];
    end else if (bypass_hit) begin
      instr_out = imem_rdata;
      instr_pc  = infl_pc_q;
    end
  end

  assign pop   = instr_valid && instr_ready;
  assign q_pop = pop && !queue_empty;
  // A bypassed word that is consumed on arrival never enters the queue.
  assign push  = infl_q && !redirect_valid && !(bypass_hit && pop);

  always_comb begin
    imem_req    = issue;
    imem_addr   = pc;
    pc_override = 1'b0;
    pc_in       = '0;
    if (!rst) begin
      if (redirect_valid) begin
        pc_override = 1'b1;
        pc_in       = redirect_pc;
      end else begin
        pc_override = !issue;
        pc_in       = pc;
      end
    end
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q + PTR_W'(q_pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    count_d   = count_q + CNT_W'(push) - CNT_W'(q_pop);
    infl_d    = issue;
    infl_pc_d = issue ? pc : infl_pc_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      infl_d   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_FLUSH: state_d = ST_RUN;
        ST_RUN:   state_d = credit_ok ? ST_RUN : ST_HOLD;
        ST_HOLD:  state_d = credit_ok ? ST_RUN : ST_HOLD;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      state_q   <= state_d;
    end
  end

  // Payload storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= infl_pc_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that consumes the address stream from `pc_ctr` and delivers fetched instructions to the decoder. Each cycle it issues the current PC to a synchronous instruction memory and captures the returned word, tagged with its PC, into a small FIFO. The decoder drains that FIFO over a valid/ready handshake. When the queue is full, or when a backend redirect arrives, the block drives `pc_ctr`'s override port to hold or retarget the PC.

## Interface
- `PC_WIDTH`, 32, width of PC and address buses.
- `INSTR_WIDTH`, 32, instruction word width.
- `DEPTH`, 4, queue entries; power of two, ≥ 2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc`  in  PC_WIDTH  current PC from `pc_ctr.pc_out`.
- `pc_override`  out  1  to `pc_ctr.pc_override`; loads `pc_in` at next edge.
- `pc_in`  out  PC_WIDTH  to `pc_ctr.pc_in`.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  PC_WIDTH  read address; equals `pc`.
- `imem_rdata`  in  INSTR_WIDTH  read data, valid exactly one cycle after a request.
- `redirect_valid`  in  1  backend redirect (branch or jump).
- `redirect_pc`  in  PC_WIDTH  redirect target.
- `instr_valid`  out  1  queue head valid.
- `instr_ready`  in  1  decoder accepts the head.
- `instr_out`  out  INSTR_WIDTH  head instruction.
- `instr_pc`  out  PC_WIDTH  PC of the head instruction.

## Operation
- State: queue (`count` 0..DEPTH, rd/wr pointers) and one in-flight flag `infl` with the tag `infl_pc`.
- Issue condition: `!redirect_valid && (count + infl) < DEPTH`. This is conservative: a pop in the same cycle does not count, so there is no combinational path from `instr_ready` to `imem_req`.
- On issue:
  - `imem_req=1`, `imem_addr=pc`, `pc_override=0`, so `pc_ctr` advances.
  - At the edge: `infl<=1`, `infl_pc<=pc`.
- No issue, no redirect: `imem_req=0`, `pc_override=1`, `pc_in=pc`. This holds the PC.
- Redirect:
  - Same cycle: `imem_req=0`, `pc_override=1`, `pc_in=redirect_pc`.
  - At the edge: queue emptied and `infl<=0`. The response arriving next cycle is discarded.
- Capture: when `infl` is set and there is no redirect, push `{imem_rdata, infl_pc}` at the edge.
- Pop: `instr_valid && instr_ready`. In the redirect cycle the pop still completes, then the flush applies.
- Push and pop in the same cycle are permitted at any count; `count` is unchanged.
- FSM, for debug visibility only (outputs derive from the conditions above):
  - RUN: issuing.
  - HOLD: credit exhausted.
  - FLUSH: redirect cycle.
  - Transitions:
    - FLUSH takes priority; FLUSH→RUN always.
    - RUN→HOLD when credit is exhausted; HOLD→RUN when credit returns.

## Timing
- Reset values:
  - `pc_override=0`, `pc_in=0`, `imem_req=0`, `imem_addr=pc`.
  - `instr_valid=0`, `instr_out=0`, `instr_pc=0`.
  - `count=0`, `infl=0`, state RUN.
- `imem_req` is suppressed while `rst` is high.
- Fetch latency:
  - Request at cycle T, data at T+1, pushed at the end of T+1.
  - `instr_valid` at T+2 (registered path).
- Redirect latency: asserted at T → `pc=redirect_pc` at T+1 (issue) → `instr_pc=redirect_pc` valid at T+3.
- Throughput is 1 instruction/cycle while the decoder pops every cycle.
- Full queue with no pop holds `pc` constant every cycle, with no skipped or duplicated PCs.
- Reset mid-operation (asynchronous): the queue and in-flight flag clear immediately and any pending response is dropped.
- `redirect_valid` during `rst` is ignored.
- Pointers wrap modulo DEPTH.

## Configuration
- `FETCH_QUEUE_BYPASS_EN`
  - Defined: when `count==0` and a response arrives, the head outputs take `imem_rdata`/`infl_pc` combinationally and `instr_valid=1` at T+1. If popped that cycle, nothing is pushed. Redirect latency becomes T+2.
  - Undefined: the registered path only, with the T+2 latency above.

## Test plan
- Reset release with `pc_ctr` counting from 0 and `instr_ready=1` → `instr_pc` sequence 0,1,2,… one per cycle from cycle 2 after the first request; `instr_out` matches memory contents.
- `instr_ready=0` for 10 cycles → `count` saturates at 4, `pc` holds at 4, `imem_req=0`. On release the PCs continue 4,5,… with no gap or duplicate.
- Redirect to 15 while 3 entries are queued and one is in flight → same-cycle `pc_in=15`; all stale entries are dropped; next `instr_pc=15` at T+3, then 16.
- Redirect in the same cycle as a pop of PC 7 → PC 7 is consumed exactly once; no other PC ≤ 8 appears after the flush.
- Assert `rst` for 3 cycles mid-stream with a full queue → `instr_valid` drops asynchronously; after release the stream restarts at PC 0.
- With `FETCH_QUEUE_BYPASS_EN`: empty queue, single request at PC 3 → `instr_valid=1`, `instr_pc=3` one cycle after the request.
